// File: rtl/alu_mc_pkg.sv
// Shared types and helpers for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OpAdd   = 5'b00001,
    OpSub   = 5'b00010,
    OpAnd   = 5'b00011,
    OpOr    = 5'b00100,
    OpSll   = 5'b00101,
    OpSrl   = 5'b00110,
    OpXor   = 5'b00111,
    OpSlt   = 5'b01000,
    OpJal   = 5'b01001,
    OpLui   = 5'b01010,
    OpSra   = 5'b01011,
    OpMul   = 5'b01100,
    OpMulh  = 5'b01101,
    OpMulhu = 5'b01110,
    OpDiv   = 5'b01111,
    OpDivu  = 5'b10000,
    OpRem   = 5'b10001,
    OpRemu  = 5'b10010
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_t;

  // Ops that use the iterative multiplier/divider.
  function automatic logic is_multicycle(op_t op);
    return op inside {OpMul, OpMulh, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_divide(op_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  // Ops whose operands are treated as two's-complement by the mul/div unit.
  function automatic logic is_signed_md(op_t op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle between operand-select, the ALU and writeback.
interface alu_mc_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            lt_flag;
  logic            ltu_flag;

  modport master (
    output in_valid, op, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, zero_flag, lt_flag, ltu_flag
  );

  modport slave (
    input  in_valid, op, operand1, operand2, out_ready,
    output in_ready, out_valid, result, zero_flag, lt_flag, ltu_flag
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with sign fix.
// Runs XLEN iterations after start, then one sign-fix cycle during which done=1
// and hi/lo carry the final signed values.
module alu_muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] mag1,
  input  logic [XLEN-1:0] mag2,
  input  logic            sign1,
  input  logic            sign2,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic              active_q, active_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              q_bit;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_neg;

  assign done = active_q && (cnt_q == '0);

  // One iteration step for each mode
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Shift the next dividend bit into the partial remainder, trial-subtract.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    q_bit    = ~rem_diff[XLEN];
    div_next = {(q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
  end

  // Sign fix: full-width negate for products, per-half negate for quotient/remainder
  always_comb begin
    acc_neg = -acc_q;
    if (is_div_q) begin
      hi = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      lo = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end else begin
      hi = neg_lo_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      lo = neg_lo_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
    end
  end

  // Next-state: load on start, iterate while counting down, retire after the fix cycle
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CW'(XLEN);
      is_div_d = is_div;
      if (is_div) begin
        acc_d    = {{XLEN{1'b0}}, mag1};
        opnd_d   = mag2;
        neg_lo_d = sign1 ^ sign2;
        neg_hi_d = sign1;
      end else begin
        acc_d    = {{XLEN{1'b0}}, mag2};
        opnd_d   = mag1;
        neg_lo_d = sign1 ^ sign2;
        neg_hi_d = sign1 ^ sign2;
      end
    end else if (active_q) begin
      if (cnt_q != '0) begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
      end else begin
        active_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle ops, RV32M mul/div, registered result and
// branch-compare flags behind valid/ready handshakes.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zf_q, zf_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;

  op_t             op_in;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            in_ready;

  logic            cmp_eq, cmp_lt, cmp_ltu;
  logic [XLEN-1:0] sc_result;
  logic            special;
  logic [XLEN-1:0] special_result;

  logic            sign1, sign2;
  logic [XLEN-1:0] mag1, mag2;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_hi, md_lo;

  assign op_in = op_t'(bus.op);
  assign a     = bus.operand1;
  assign b     = bus.operand2;
  assign shamt = b[SHW-1:0];

  assign in_ready = rst_n && ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero_flag = zf_q;
  assign bus.lt_flag   = lt_q;
  assign bus.ltu_flag  = ltu_q;

  assign cmp_eq  = (a == b);
  assign cmp_lt  = ($signed(a) < $signed(b));
  assign cmp_ltu = (a < b);

  // Single-cycle datapath; unknown opcodes yield zero
  always_comb begin
    sc_result = '0;
    case (op_in)
      OpAdd:   sc_result = a + b;
      OpSub:   sc_result = a - b;
      OpAnd:   sc_result = a & b;
      OpOr:    sc_result = a | b;
      OpXor:   sc_result = a ^ b;
      OpSll:   sc_result = a << shamt;
      OpSrl:   sc_result = a >> shamt;
      OpSra:   sc_result = $signed(a) >>> shamt;
      OpSlt:   sc_result = {{(XLEN-1){1'b0}}, cmp_lt};
      OpJal:   sc_result = b + XLEN'(4);
      OpLui:   sc_result = b;
      default: sc_result = '0;
    endcase
  end

  // Division corner cases that bypass the iterative unit
  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (is_divide(op_in)) begin
      if (b == '0) begin
        special        = 1'b1;
        special_result = (op_in inside {OpDiv, OpDivu}) ? '1 : a;
      end else if ((op_in inside {OpDiv, OpRem}) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
        special        = 1'b1;
        special_result = (op_in == OpDiv) ? a : '0;
      end
    end
  end

  // Operand magnitudes and signs for the iterative unit
  always_comb begin
    sign1 = is_signed_md(op_in) && a[XLEN-1];
    sign2 = is_signed_md(op_in) && b[XLEN-1];
    mag1  = sign1 ? -a : a;
    mag2  = sign2 ? -b : b;
  end

  alu_muldiv_seq #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (is_divide(op_in)),
    .mag1   (mag1),
    .mag2   (mag2),
    .sign1  (sign1),
    .sign2  (sign2),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // FSM next-state, result capture and mul/div launch
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    zf_d     = zf_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    md_start = 1'b0;

    unique case (state_q)
      StIdle: ;
      StBusy: begin
        if (md_done) begin
          result_d = (op_q inside {OpMul, OpDiv, OpDivu}) ? md_lo : md_hi;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides the transitions above (IDLE, or DONE being drained)
    if (accept) begin
      op_d  = op_in;
      zf_d  = cmp_eq;
      lt_d  = cmp_lt;
      ltu_d = cmp_ltu;
      if (is_multicycle(op_in) && !special) begin
        md_start = 1'b1;
        state_d  = StBusy;
      end else begin
        result_d = special ? special_result : sc_result;
        state_d  = StDone;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      result_q <= '0;
      zf_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc plus hand-written handshake/reset sequences.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int NVEC = 24;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vecs [NVEC];

  alu_mc_if #(.XLEN(XLEN)) bus ();

  alu_mc #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE, return result/flags and latency in edges from accept.
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic lt,
                       output logic ltu, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.operand1  = a;
    bus.operand2  = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.operand1 = ~a;
    bus.operand2 = ~b;
    bus.op       = 5'b00000;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r   = bus.result;
    z   = bus.zero_flag;
    lt  = bus.lt_flag;
    ltu = bus.ltu_flag;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        z, lt, ltu;
  int          lat;

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            op       a             b             result        z     lt    ltu   lat
    vecs[0]  = '{OpAdd,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{OpSub,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1};
    vecs[2]  = '{OpAnd,   32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{OpOr,    32'h00001200, 32'h00000034, 32'h00001234, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{OpXor,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{OpSll,   32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b1, 1'b1, 1};
    vecs[6]  = '{OpSrl,   32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{OpSlt,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{OpJal,   32'h00000000, 32'h00000100, 32'h00000104, 1'b0, 1'b1, 1'b1, 1};
    vecs[9]  = '{OpLui,   32'h00000000, 32'hABCDE000, 32'hABCDE000, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{OpSra,   32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{5'b11111, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{OpMulh,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 34};
    vecs[13] = '{OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 34};
    vecs[14] = '{OpMul,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0, 34};
    vecs[15] = '{OpDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 34};
    vecs[16] = '{OpRem,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 34};
    vecs[17] = '{OpDivu,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1, 1};
    vecs[19] = '{OpRem,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1};
    vecs[20] = '{OpRemu,  32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 1'b0, 1'b0, 1};
    vecs[21] = '{OpDivu,  32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, 1'b0, 34};
    vecs[22] = '{OpRemu,  32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0, 1'b0, 34};
    vecs[23] = '{OpMulhu, 32'h12345678, 32'h00000100, 32'h00000012, 1'b0, 1'b0, 1'b0, 34};

    // Reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 5'b00000;
    bus.operand1  = '0;
    bus.operand2  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_flags", 64'({bus.zero_flag, bus.lt_flag, bus.ltu_flag}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Table-driven single ops
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lt, ltu, lat);
      check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'({z, lt, ltu}),
            64'({vecs[i].z, vecs[i].lt, vecs[i].ltu}));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: DIV result held while a pending ADD waits
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = OpDiv;
    bus.operand1  = 32'hFFFFFFF9;
    bus.operand2  = 32'h00000002;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.op       = OpAdd;
    bus.operand1 = 32'd2;
    bus.operand2 = 32'd3;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd34);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", 64'(bus.result), 64'hFFFFFFFD);
      check("bp_hold_valid_ready_flags",
            64'({bus.out_valid, bus.in_ready, bus.zero_flag, bus.lt_flag, bus.ltu_flag}),
            64'b10010);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_on_drain", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_next_add_valid", 64'(bus.out_valid), 64'd1);
    check("bp_next_add_result", 64'(bus.result), 64'd5);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Back-to-back ADDs, one result per cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.op        = OpAdd;
      bus.operand1  = 32'(i);
      bus.operand2  = 32'd100;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d", i), 64'({bus.out_valid, bus.result}),
            64'({1'b1, 32'(100 + i)}));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("b2b_drained", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a MUL
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = OpMul;
    bus.operand1  = 32'd3;
    bus.operand2  = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_stale_valid", 64'(bus.out_valid), 64'd0);
    do_op(OpMul, 32'd3, 32'd7, r, z, lt, ltu, lat);
    check("midrst_fresh_result", 64'(r), 64'd21);
    check("midrst_fresh_latency", 64'(lat), 64'd34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
